face_detect_mul_pipe_vld: RTL and testbench

FACE_DETECT_MUL_PIPE_VLD -- requirements
Module: face_detect_mul_pipe_vld

---
 rtl/face_detect_mul_pipe_vld.sv | 168 ++++++++++++++++
 tb/tb_face_detect_mul_pipe_vld.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detect_mul_pipe_vld.sv
// face_detect_mul_pipe_vld: pipelined A x B multiplier with a valid/ready
// handshake. The whole pipe moves forward only when the output side can
// accept (advance), so a stall freezes every stage including bubbles.
// Stage 1 holds the operands, stage 2 the full product, stages 3..NUM_STAGE-1
// delay the product, and stage NUM_STAGE holds the shifted, range-limited result.
// Optional feature macro: FACE_DETECT_MUL_SAT_EN (saturate instead of wrap).
module face_detect_mul_pipe_vld #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 7,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 1,
    parameter int NUM_STAGE = 4,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat,
    output logic                 busy
);

    localparam int P        = A_WIDTH + B_WIDTH;
    localparam bit P_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

    logic                 advance;
    logic [NUM_STAGE-1:0] vld_q, vld_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [P-1:0]         a_ext;
    logic [P-1:0]         b_ext;
    logic [P-1:0]         prod_c;
    logic [P-1:0]         lim_in;
    logic [P-1:0]         shifted;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;
    logic                 sat_q, sat_d;
`ifdef FACE_DETECT_MUL_SAT_EN
    logic                 ovf;
    logic [OUT_WIDTH-1:0] clamp;
`endif

    assign advance   = !vld_q[NUM_STAGE-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NUM_STAGE-1];
    assign busy      = |vld_q;
    assign dout      = dout_q;
    assign sat       = sat_q;

    // Valid shift register and stage-1 operand capture, both gated by advance.
    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        if (advance) begin
            vld_d = {vld_q[NUM_STAGE-2:0], in_valid};
            a_d   = din0;
            b_d   = din1;
        end
    end

    // Stage-1 registers and valid bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    // Extend both operands to the full product width; the low P bits of a
    // P x P multiply are then exact for any signedness mix.
    always_comb begin
        if (A_SIGNED != 0) a_ext = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q};
        else               a_ext = {{B_WIDTH{1'b0}}, a_q};
        if (B_SIGNED != 0) b_ext = {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
        else               b_ext = {{A_WIDTH{1'b0}}, b_q};
        prod_c = a_ext * b_ext;
    end

    // With NUM_STAGE == 2 the product stage and the final stage coincide, so
    // the limiter reads the combinational product directly.
    generate
        if (NUM_STAGE > 2) begin : g_delay
            logic [P-1:0] pd_q [NUM_STAGE-2];
            logic [P-1:0] pd_d [NUM_STAGE-2];

            // Product register (index 0) followed by pure delay stages.
            always_comb begin
                pd_d = pd_q;
                if (advance) begin
                    pd_d[0] = prod_c;
                    for (int unsigned i = 1; i < NUM_STAGE - 2; i++) begin
                        pd_d[i] = pd_q[i-1];
                    end
                end
            end

            // Product and delay-stage registers.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned i = 0; i < NUM_STAGE - 2; i++) begin
                        pd_q[i] <= '0;
                    end
                end else begin
                    pd_q <= pd_d;
                end
            end

            assign lim_in = pd_q[NUM_STAGE-3];
        end else begin : g_direct
            assign lim_in = prod_c;
        end
    endgenerate

    // Shift and range-limit the product into the final stage.
    always_comb begin
        dout_d = dout_q;
        sat_d  = sat_q;
        if (P_SIGNED) shifted = $signed(lim_in) >>> SHIFT;
        else          shifted = lim_in >> SHIFT;
`ifdef FACE_DETECT_MUL_SAT_EN
        ovf   = 1'b0;
        clamp = '1;
        if (P_SIGNED) begin
            for (int unsigned i = OUT_WIDTH; i < P; i++) begin
                if (shifted[i] != shifted[OUT_WIDTH-1]) ovf = 1'b1;
            end
            clamp                = {OUT_WIDTH{~shifted[P-1]}};
            clamp[OUT_WIDTH-1]   = shifted[P-1];
        end else begin
            for (int unsigned i = OUT_WIDTH; i < P; i++) begin
                if (shifted[i]) ovf = 1'b1;
            end
        end
`endif
        if (advance) begin
`ifdef FACE_DETECT_MUL_SAT_EN
            dout_d = ovf ? clamp : OUT_WIDTH'(shifted);
            sat_d  = ovf;
`else
            dout_d = OUT_WIDTH'(shifted);
            sat_d  = 1'b0;
`endif
        end
    end

    // Final-stage result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: tb/tb_face_detect_mul_pipe_vld.sv
// Directed testbench for face_detect_mul_pipe_vld: default configuration
// (latency, streaming, stall, reset flush) plus a signed 8x8 saturating/wrapping
// instance and an unsigned 8x8 shifted instance. Follows FACE_DETECT_MUL_SAT_EN.
module tb_face_detect_mul_pipe_vld;

`ifdef FACE_DETECT_MUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    // default instance
    logic        in_valid, in_ready, out_valid, out_ready, sat, busy;
    logic [15:0] din0;
    logic [6:0]  din1;
    logic [22:0] dout;

    // signed 8x8 -> 8, two stages
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sat, s_busy;
    logic [7:0] s_din0, s_din1, s_dout;

    // unsigned 8x8, shift 4 -> 12, six stages
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_sat, u_busy;
    logic [7:0]  u_din0, u_din1;
    logic [11:0] u_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [22:0] exp_q [$];
    int cyc = 0;
    int last_out_cyc = -10;
    int run_len = 0;
    int max_run = 0;
    int n_out = 0;

    // Hand-computed 23-bit results of va[i] (unsigned) * vb[i] (signed 7-bit).
    logic [15:0] va [10] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h1234, 16'h0001,
                             16'hFFFF, 16'h8000, 16'hABCD, 16'h00FF, 16'h0F0F};
    logic [6:0]  vb [10] = '{7'h40, 7'h05, 7'h3F, 7'h7F, 7'h40,
                             7'h3F, 7'h01, 7'h15, 7'h7E, 7'h00};
    logic [22:0] ve [10] = '{23'h400040, 23'h000000, 23'h1F7FC1, 23'h7FEDCC, 23'h7FFFC0,
                             23'h3EFFC1, 23'h008000, 23'h0E17D1, 23'h7FFE02, 23'h000000};

    face_detect_mul_pipe_vld u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat(sat),
        .busy(busy)
    );

    face_detect_mul_pipe_vld #(
        .A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
        .NUM_STAGE(2), .SHIFT(0), .OUT_WIDTH(8)
    ) u_s8 (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .din0(s_din0), .din1(s_din1),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .sat(s_sat),
        .busy(s_busy)
    );

    face_detect_mul_pipe_vld #(
        .A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(0), .B_SIGNED(0),
        .NUM_STAGE(6), .SHIFT(4), .OUT_WIDTH(12)
    ) u_u12 (
        .clk(clk), .reset(reset),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .din0(u_din0), .din1(u_din1),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .dout(u_dout), .sat(u_sat),
        .busy(u_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock window of the default instance: drive at the falling edge,
    // then score the handshakes that the next rising edge will perform.
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [6:0] b,
                         input logic [22:0] e_in, input logic ordy, output logic acc);
        logic [22:0] e;
        @(negedge clk);
        in_valid  = iv;
        din0      = a;
        din1      = b;
        out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            n_out++;
            if (last_out_cyc == cyc - 1) run_len++;
            else                         run_len = 1;
            if (run_len > max_run) max_run = run_len;
            last_out_cyc = cyc;
            check_eq("out_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("dout", dout, e);
            end
            check_eq("sat", sat, 0);
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(e_in);
    endtask

    task automatic run_s8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_s);
        int lat;
        @(negedge clk);
        s_in_valid = 1'b1; s_din0 = a; s_din1 = b; s_out_ready = 1'b1;
        #1 check_eq({tag, "_in_ready"}, s_in_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            s_in_valid = 1'b0;
            #1 lat++;
        end while (!s_out_valid && lat < 12);
        check_eq({tag, "_lat"}, lat, 2);
        check_eq({tag, "_dout"}, s_dout, exp_d);
        check_eq({tag, "_sat"}, s_sat, exp_s);
    endtask

    task automatic run_u12(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [11:0] exp_d);
        int lat;
        @(negedge clk);
        u_in_valid = 1'b1; u_din0 = a; u_din1 = b; u_out_ready = 1'b1;
        #1 check_eq({tag, "_in_ready"}, u_in_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            u_in_valid = 1'b0;
            #1 lat++;
        end while (!u_out_valid && lat < 16);
        check_eq({tag, "_lat"}, lat, 6);
        check_eq({tag, "_dout"}, u_dout, exp_d);
        check_eq({tag, "_sat"}, u_sat, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   idx;

        clk = 1'b0; reset = 1'b1;
        in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_din0 = '0; s_din1 = '0; s_out_ready = 1'b0;
        u_in_valid = 1'b0; u_din0 = '0; u_din1 = '0; u_out_ready = 1'b0;
        #2 reset = 1'b0;

        // reset state, with out_ready low to show in_ready does not need it
        @(negedge clk); #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_sat", sat, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk) reset = 1'b1;

        // single operation latency: 0xFFFF * -64
        @(negedge clk);
        in_valid = 1'b1; din0 = 16'hFFFF; din1 = 7'h40; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1 check_eq($sformatf("lat_vld_c%0d", i), out_valid, 32'(i == 4));
            if (i == 1) check_eq("lat_busy", busy, 1);
        end
        check_eq("lat_dout", dout, 23'h400040);
        check_eq("lat_sat", sat, 0);
        @(negedge clk); #1;
        check_eq("lat_drained_vld", out_valid, 0);
        check_eq("lat_drained_busy", busy, 0);

        // back-to-back stream
        exp_q.delete(); n_out = 0; run_len = 0; max_run = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, va[i], vb[i], ve[i], 1'b1, acc);
            check_eq("b2b_acc", acc, 1);
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
        check_eq("b2b_count", n_out, 10);
        check_eq("b2b_run", max_run, 10);
        check_eq("b2b_empty", exp_q.size(), 0);

        // stall with a full pipe, then release
        exp_q.delete(); n_out = 0; idx = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, va[idx], vb[idx], ve[idx], 1'b0, acc);
            if (acc) idx++;
        end
        check_eq("fill_acc", idx, 4);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, va[idx], vb[idx], ve[idx], 1'b0, acc);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_dout", dout, ve[0]);
            if (acc) idx++;
        end
        check_eq("stall_no_acc", idx, 4);
        for (int k = 0; k < 40 && (idx < 10 || exp_q.size() != 0); k++) begin
            if (idx < 10) cycle(1'b1, va[idx], vb[idx], ve[idx], 1'b1, acc);
            else          cycle(1'b0, '0, '0, '0, 1'b1, acc);
            if (acc) idx++;
        end
        check_eq("stall_fed", idx, 10);
        check_eq("stall_count", n_out, 10);
        check_eq("stall_empty", exp_q.size(), 0);

        // reset with three operations in flight
        exp_q.delete(); n_out = 0;
        for (int k = 0; k < 3; k++) cycle(1'b1, va[k+3], vb[k+3], ve[k+3], 1'b1, acc);
        @(negedge clk);
        check_eq("inflight_busy", busy, 1);
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        check_eq("mrst_out_valid", out_valid, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_dout", dout, 0);
        check_eq("mrst_sat", sat, 0);
        check_eq("mrst_in_ready", in_ready, 1);
        @(negedge clk); #1;
        check_eq("mrst_hold_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, acc);
            check_eq("post_rst_quiet", out_valid, 0);
        end
        check_eq("post_rst_stale", n_out, 0);
        cycle(1'b1, 16'h0003, 7'h05, 23'h00000F, 1'b1, acc);
        check_eq("post_rst_acc", acc, 1);
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
        check_eq("post_rst_count", n_out, 1);

        // signed 8x8 -> 8
        run_s8("s8_100x100",   8'h64, 8'h64, SAT_EN ? 8'h7F : 8'h10, SAT_EN);
        run_s8("s8_m100x100",  8'h9C, 8'h64, SAT_EN ? 8'h80 : 8'hF0, SAT_EN);
        run_s8("s8_m5x7",      8'hFB, 8'h07, 8'hDD, 1'b0);
        run_s8("s8_m128xm1",   8'h80, 8'hFF, SAT_EN ? 8'h7F : 8'h80, SAT_EN);

        // unsigned 8x8 >> 4 -> 12
        run_u12("u12_ffxff",   8'hFF, 8'hFF, 12'hFE0);
        run_u12("u12_0fx01",   8'h0F, 8'h01, 12'h000);
        run_u12("u12_80x03",   8'h80, 8'h03, 12'h018);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
